// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: widths, reset/bubble defaults, IF/ID payload.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t PC_RESET_DEFAULT  = 32'h0000_0000;
  localparam word_t NOP_INSTR_DEFAULT = 32'h0000_0000;  // sll $0,$0,0
  localparam word_t PC_STEP           = 32'd4;

  // IF/ID pipeline register payload
  typedef struct packed {
    logic  valid;
    word_t pc;
    word_t pc4;
    word_t instr;
  } ifid_t;

  // Force a byte address onto a word boundary
  function automatic word_t align_pc(input word_t addr);
    return addr & ~word_t'(3);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/EX controls in, instruction memory, IF/ID outputs.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic  stall_i;
  logic  redirect_i;
  word_t redirect_pc_i;
  word_t im_addr_o;
  word_t im_rdata_i;
  logic  ifid_valid_o;
  word_t ifid_pc_o;
  word_t ifid_pc4_o;
  word_t ifid_instr_o;
  logic  misalign_o;
  word_t fetch_count_o;

  // Fetch-stage side
  modport master (
    input  stall_i, redirect_i, redirect_pc_i, im_rdata_i,
    output im_addr_o, ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o,
           misalign_o, fetch_count_o
  );

  // Environment side (hazard unit, EX, instruction memory, decode)
  modport slave (
    output stall_i, redirect_i, redirect_pc_i, im_rdata_i,
    input  im_addr_o, ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o,
           misalign_o, fetch_count_o
  );

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register with hold (default), load and bubble controls.
module fetch_stage_ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  load_i,
  input  logic  bubble_i,
  input  word_t pc_i,
  input  word_t instr_i,
  output ifid_t ifid_o
);

  ifid_t ifid_d;
  ifid_t ifid_q;

  // Bubble wins over load; a bubble keeps pc/pc4 of the squashed slot
  always_comb begin
    ifid_d = ifid_q;
    if (bubble_i) begin
      ifid_d.valid = 1'b0;
      ifid_d.instr = NOP_INSTR;
    end else if (load_i) begin
      ifid_d.valid = 1'b1;
      ifid_d.pc    = pc_i;
      ifid_d.pc4   = pc_i + PC_STEP;
      ifid_d.instr = instr_i;
    end
  end

  // IF/ID state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ifid_q.valid <= 1'b0;
      ifid_q.pc    <= '0;
      ifid_q.pc4   <= '0;
      ifid_q.instr <= NOP_INSTR;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign ifid_o = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, next-PC select, fetch counter, misalign flag, IF/ID.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t PC_RESET  = PC_RESET_DEFAULT,
  parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input logic           clock,
  input logic           reset,
  fetch_stage_if.master bus
);

  word_t pc_d,    pc_q;
  word_t count_d, count_q;
  logic  misalign_d, misalign_q;
  logic  load_c;
  logic  bubble_c;
  ifid_t ifid;

  // Next-PC select: redirect (squash) > stall (hold) > sequential fetch
  always_comb begin
    pc_d       = pc_q;
    count_d    = count_q;
    misalign_d = misalign_q;
    load_c     = 1'b0;
    bubble_c   = 1'b0;
    if (bus.redirect_i) begin
      pc_d     = align_pc(bus.redirect_pc_i);
      bubble_c = 1'b1;
      if (bus.redirect_pc_i[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else if (!bus.stall_i) begin
      pc_d    = pc_q + PC_STEP;
      count_d = count_q + 32'd1;
      load_c  = 1'b1;
    end
  end

  // PC, counter and sticky misalign registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q       <= PC_RESET;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_stage_ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clock    (clock),
    .reset    (reset),
    .load_i   (load_c),
    .bubble_i (bubble_c),
    .pc_i     (pc_q),
    .instr_i  (bus.im_rdata_i),
    .ifid_o   (ifid)
  );

  assign bus.im_addr_o     = pc_q;
  assign bus.ifid_valid_o  = ifid.valid;
  assign bus.ifid_pc_o     = ifid.pc;
  assign bus.ifid_pc4_o    = ifid.pc4;
  assign bus.ifid_instr_o  = ifid.instr;
  assign bus.misalign_o    = misalign_q;
  assign bus.fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage against a behavioural model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic clk;
  logic rst_n;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // Instruction memory: 256 words, mirrored across the address space
  logic [31:0] mem [256];
  assign bus.im_rdata_i = mem[bus.im_addr_o[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_pass;

  // Reference model of the architectural state
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_ifpc;
  logic [31:0] m_pc4;
  logic [31:0] m_instr;
  logic        m_mis;
  logic [31:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_valid = 1'b0; m_ifpc = 32'h0; m_pc4 = 32'h0;
    m_instr = 32'h0; m_mis = 1'b0; m_cnt = 32'h0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".im_addr"}, bus.im_addr_o,          m_pc);
    check({tag, ".valid"},   32'(bus.ifid_valid_o),  32'(m_valid));
    check({tag, ".pc"},      bus.ifid_pc_o,          m_ifpc);
    check({tag, ".pc4"},     bus.ifid_pc4_o,         m_pc4);
    check({tag, ".instr"},   bus.ifid_instr_o,       m_instr);
    check({tag, ".mis"},     32'(bus.misalign_o),    32'(m_mis));
    check({tag, ".count"},   bus.fetch_count_o,      m_cnt);
  endtask

  // One clock: apply inputs, advance model, sample #1 after the edge
  task automatic step(input logic stall, input logic redir, input logic [31:0] rpc,
                      input string tag);
    bus.stall_i       = stall;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = rpc;
    @(posedge clk);
    if (redir) begin
      m_pc    = {rpc[31:2], 2'b00};
      m_valid = 1'b0;
      m_instr = 32'h0;
      if (rpc[1:0] != 2'b00) m_mis = 1'b1;
    end else if (!stall) begin
      m_valid = 1'b1;
      m_ifpc  = m_pc;
      m_pc4   = m_pc + 32'd4;
      m_instr = mem[m_pc[9:2]];
      m_pc    = m_pc + 32'd4;
      m_cnt   = m_cnt + 32'd1;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h00a63824;
    mem[1] = 32'h214b002d;
    mem[2] = 32'h00430820;
    mem[8] = 32'h200d002d;
    bus.stall_i = 1'b0; bus.redirect_i = 1'b0; bus.redirect_pc_i = 32'h0;
    rst_n = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Free run from reset
    step(1'b0, 1'b0, 32'h0, "run1");
    check("run1.instr_k", bus.ifid_instr_o, 32'h00a63824);
    step(1'b0, 1'b0, 32'h0, "run2");
    check("run2.pc4_k",   bus.ifid_pc4_o,    32'h8);
    check("run2.count_k", bus.fetch_count_o, 32'd2);

    // Two-cycle stall at PC=8, then resume
    step(1'b1, 1'b0, 32'h0, "stall1");
    step(1'b1, 1'b0, 32'h0, "stall2");
    check("stall2.addr_k", bus.im_addr_o, 32'h8);
    step(1'b0, 1'b0, 32'h0, "resume");
    check("resume.instr_k", bus.ifid_instr_o, 32'h00430820);

    // Redirect overrides stall
    step(1'b1, 1'b1, 32'h20, "redir20");
    check("redir20.addr_k", bus.im_addr_o, 32'h20);
    step(1'b0, 1'b0, 32'h0, "tgt20");
    check("tgt20.instr_k", bus.ifid_instr_o, 32'h200d002d);

    // Misaligned target, then sticky through an aligned redirect
    step(1'b0, 1'b1, 32'h13, "mis13");
    check("mis13.addr_k", bus.im_addr_o, 32'h10);
    step(1'b0, 1'b0, 32'h0, "mis_run");
    step(1'b0, 1'b1, 32'h40, "mis_sticky");
    check("mis_sticky.k", 32'(bus.misalign_o), 32'd1);

    // Wrap at top of address space
    step(1'b0, 1'b1, 32'hFFFF_FFFC, "redir_top");
    step(1'b0, 1'b0, 32'h0, "wrap1");
    check("wrap1.pc_k", bus.ifid_pc_o, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, "wrap2");

    // Async reset mid-stream at PC=0x14, count=5
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_mid0");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, "pre_rst");
    check("pre_rst.addr_k", bus.im_addr_o, 32'h14);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 32'h0, "post_rst");
    check("post_rst.instr_k", bus.ifid_instr_o, 32'h00a63824);

    // Random phase
    for (int i = 0; i < 400; i++) begin
      logic        st;
      logic        rd;
      logic [31:0] tgt;
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 6) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
      else if ($urandom_range(0, 1) == 0) tgt = tgt & ~32'h3;
      step(st, rd, tgt, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipeline CPU, feeding the decode stage. Holds the program counter, drives the instruction-memory address, and registers fetched instructions into the IF/ID pipeline register. Honours load-use stalls from the hazard unit and branch/jump redirects resolved in EX. Keeps a retired-fetch counter for bench and performance checks.

## Interface
Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0000, bubble encoding (sll $0,$0,0)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- stall_i  input  1  hazard unit: hold PC and IF/ID contents
- redirect_i  input  1  EX: taken branch/jump this cycle
- redirect_pc_i  input  32  EX: target byte address
- im_addr_o  output  32  instruction-memory byte address (= PC)
- im_rdata_i  input  32  instruction word, combinational from im_addr_o
- ifid_valid_o  output  1  IF/ID holds a real instruction
- ifid_pc_o  output  32  PC of IF/ID instruction
- ifid_pc4_o  output  32  ifid_pc_o + 4
- ifid_instr_o  output  32  IF/ID instruction word
- misalign_o  output  1  sticky: a redirect target had bits [1:0] ≠ 0
- fetch_count_o  output  32  number of valid instructions loaded into IF/ID

## Operation
- Reset asserted (low), any time: PC=PC_RESET, ifid_valid_o=0, ifid_instr_o=NOP_INSTR, ifid_pc_o=0, ifid_pc4_o=0, misalign_o=0, fetch_count_o=0. Aborts any in-progress redirect/stall.
- im_addr_o = PC, continuously.
- Each rising edge, priority order:
  - redirect_i=1 (overrides stall_i): PC ← {redirect_pc_i[31:2],2'b00}; IF/ID ← bubble (valid=0, instr=NOP_INSTR, pc/pc4 unchanged); misalign_o set if redirect_pc_i[1:0]≠0.
  - else stall_i=1: PC and IF/ID hold; counter holds.
  - else: IF/ID ← {valid=1, pc=PC, pc4=PC+4, instr=im_rdata_i}; PC ← PC+4; fetch_count_o increments.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. fetch_count_o wraps likewise.
- misalign_o cleared only by reset.
- No FSM beyond PC/valid registers; the "states" are RUN, HOLD (stall), SQUASH (redirect), each lasting exactly the cycle of its input.

## Timing
- Fetch latency: instruction at PC appears on ifid_instr_o one edge after PC is presented.
- First edge after reset release: IF/ID = IM[PC_RESET], PC = PC_RESET+4.
- Redirect penalty: one bubble; target instruction reaches IF/ID on the second edge after redirect_i sampled.
- Inputs sampled only on the rising edge; stall_i/redirect_i are single-cycle-level, no handshake.
- Outputs are registered except im_addr_o (from PC register, also glitch-free).

## Structure
- Shared header pipeline_defs.vh: instruction/address widths, NOP encoding, PC_RESET default; also used by decode and hazard units.
- One sub-module: ifid_reg (valid/pc/pc4/instr register with hold and bubble-load controls); PC register, next-PC mux, counter and misalign flag live in fetch_stage.

## Test plan
- Reset then free run with IM[0]=32'h00a63824, IM[1]=32'h214b002d: after edge 1 ifid_instr_o=00a63824, ifid_pc_o=0; after edge 2 ifid_instr_o=214b002d, ifid_pc_o=4, ifid_pc4_o=8, fetch_count_o=2.
- stall_i high for 2 cycles at PC=8: ifid_pc_o stays 4, im_addr_o stays 8, fetch_count_o unchanged; fetching resumes with IM[2]=00430820.
- redirect_i with redirect_pc_i=32'h20 while stall_i=1: next edge ifid_valid_o=0, ifid_instr_o=0, im_addr_o=0x20; following edge ifid_pc_o=0x20, ifid_instr_o=IM[8]=200d002d.
- redirect_pc_i=32'h0000_0013: im_addr_o=0x10, misalign_o=1 and remains 1 through later redirects until reset.
- Redirect to 32'hFFFF_FFFC, run 2 cycles: ifid_pc_o=FFFF_FFFC then im_addr_o=0, ifid_pc4_o=0.
- Assert reset mid-stream (PC=0x14, valid=1, count=5): outputs return to reset values immediately without a clock edge; after release fetch restarts at PC_RESET.
